spi_master_fifo: RTL and testbench

Byte-oriented SPI master with small TX and RX FIFOs. It is the stage directly downstream of the sensor-app SPI sequencers: they push command/dummy bytes with Write_i, pop received bytes with ReadNext_i, and watch Transmission_o. It drives SCK/MOSI and samples MISO with runtime-selectable CPOL, CPHA and bit order. Chip select is not part of this block; the sequencer drives it.

---
 rtl/spi_master_fifo.sv | 197 +++++++++++++++++++
 tb/tb_spi_master_fifo.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_fifo.sv
// Byte-oriented SPI master. A TX FIFO feeds a shift engine whose mode and baud
// settings are captured per word; completed words land in an RX FIFO.
module spi_master_fifo #(
   parameter int DataWidth = 8,
   parameter int FIFOWidth = 2,
   parameter int SPPRWidth = 4,
   parameter int SPRWidth  = 3
) (
   input  logic                 Clk_i,
   input  logic                 Reset_i,
   input  logic                 CPOL_i,
   input  logic                 CPHA_i,
   input  logic                 LSBFE_i,
   input  logic [SPPRWidth-1:0] SPPR_i,
   input  logic [SPRWidth-1:0]  SPR_i,
   input  logic                 Write_i,
   input  logic [DataWidth-1:0] Data_i,
   input  logic                 ReadNext_i,
   output logic [DataWidth-1:0] Data_o,
   output logic                 FIFOFull_o,
   output logic                 FIFOEmpty_o,
   output logic                 Transmission_o,
   output logic                 SCK_o,
   output logic                 MOSI_o,
   input  logic                 MISO_i
);
   localparam int Depth = 1 << FIFOWidth;
   localparam int EdgeW = $clog2(2 * DataWidth);
   localparam int BitW  = $clog2(DataWidth);
   localparam int HW    = SPPRWidth + (1 << SPRWidth);

   typedef enum logic {IDLE, SHIFT} state_t;
   typedef logic [DataWidth-1:0] word_t;

   word_t                tx_mem_q [Depth];
   word_t                tx_mem_d [Depth];
   word_t                rx_mem_q [Depth];
   word_t                rx_mem_d [Depth];
   logic [FIFOWidth-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [FIFOWidth-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [FIFOWidth:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic                 tx_full_q, tx_full_d;
   state_t               state_q, state_d;
   logic                 cpol_q, cpol_d, cpha_q, cpha_d, lsbfe_q, lsbfe_d;
   logic [HW-1:0]        half_q, half_d, div_q, div_d;
   logic [EdgeW-1:0]     edge_q, edge_d;
   word_t                tx_word_q, tx_word_d, rx_word_q, rx_word_d;
   logic                 sck_q, sck_d, mosi_q, mosi_d, busy_q, busy_d;
   logic                 tx_push, tx_pop, rx_push, rx_pop, rx_wr_en;
   word_t                rx_in;

   function automatic logic [BitW-1:0] bpos(input logic lsb, input logic [BitW-1:0] k);
      return lsb ? k : BitW'(DataWidth - 1) - k;
   endfunction

   always_comb begin
      tx_mem_d  = tx_mem_q;
      rx_mem_d  = rx_mem_q;
      tx_wr_d   = tx_wr_q;
      tx_rd_d   = tx_rd_q;
      tx_cnt_d  = tx_cnt_q;
      rx_wr_d   = rx_wr_q;
      rx_rd_d   = rx_rd_q;
      rx_cnt_d  = rx_cnt_q;
      state_d   = state_q;
      cpol_d    = cpol_q;
      cpha_d    = cpha_q;
      lsbfe_d   = lsbfe_q;
      half_d    = half_q;
      div_d     = div_q;
      edge_d    = edge_q;
      tx_word_d = tx_word_q;
      rx_word_d = rx_word_q;
      sck_d     = sck_q;
      mosi_d    = mosi_q;
      busy_d    = busy_q;
      tx_push   = Write_i & ~tx_full_q;
      tx_pop    = 1'b0;
      rx_push   = 1'b0;
      rx_pop    = ReadNext_i & (rx_cnt_q != '0);
      rx_in     = rx_word_q;

      if (state_q == IDLE) begin
         sck_d  = CPOL_i;
         mosi_d = 1'b0;
         busy_d = 1'b0;
      end else if (div_q == half_q - HW'(1)) begin
         div_d  = '0;
         edge_d = edge_q + EdgeW'(1);
         sck_d  = ~sck_q;
         // Edge parity equal to CPHA is a sample edge, the other parity launches the next bit.
         if (edge_q[0] == cpha_q)
            rx_in[bpos(lsbfe_q, BitW'(edge_q >> 1))] = MISO_i;
         else
            mosi_d = tx_word_q[bpos(lsbfe_q, BitW'((edge_q + EdgeW'(1)) >> 1))];
         rx_word_d = rx_in;
         if (edge_q == EdgeW'(2 * DataWidth - 1)) begin
            rx_push = 1'b1;
            state_d = IDLE;
            busy_d  = 1'b0;
            sck_d   = cpol_q;
            mosi_d  = 1'b0;
         end
      end else begin
         div_d = div_q + HW'(1);
      end

      // Loading from Idle and back-to-back reload at the final edge share this path.
      if ((state_d == IDLE) && (tx_cnt_q != '0)) begin
         tx_pop    = 1'b1;
         state_d   = SHIFT;
         busy_d    = 1'b1;
         cpol_d    = CPOL_i;
         cpha_d    = CPHA_i;
         lsbfe_d   = LSBFE_i;
         half_d    = (HW'(SPPR_i) + HW'(1)) << SPR_i;
         div_d     = '0;
         edge_d    = '0;
         sck_d     = CPOL_i;
         rx_word_d = '0;
         tx_word_d = tx_mem_q[tx_rd_q];
         mosi_d    = CPHA_i ? 1'b0 : (LSBFE_i ? tx_mem_q[tx_rd_q][0]
                                              : tx_mem_q[tx_rd_q][DataWidth-1]);
      end

      if (tx_push) begin
         tx_mem_d[tx_wr_q] = Data_i;
         tx_wr_d = tx_wr_q + FIFOWidth'(1);
      end
      if (tx_pop) tx_rd_d = tx_rd_q + FIFOWidth'(1);
      if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + (FIFOWidth+1)'(1);
      else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - (FIFOWidth+1)'(1);
      tx_full_d = (tx_cnt_d == (FIFOWidth+1)'(Depth));

      rx_wr_en = rx_push & ((rx_cnt_q != (FIFOWidth+1)'(Depth)) | rx_pop);
      if (rx_wr_en) begin
         rx_mem_d[rx_wr_q] = rx_in;
         rx_wr_d = rx_wr_q + FIFOWidth'(1);
      end
      if (rx_pop) rx_rd_d = rx_rd_q + FIFOWidth'(1);
      if (rx_wr_en && !rx_pop) rx_cnt_d = rx_cnt_q + (FIFOWidth+1)'(1);
      else if (!rx_wr_en && rx_pop) rx_cnt_d = rx_cnt_q - (FIFOWidth+1)'(1);
   end

   always_ff @(posedge Clk_i) begin
      tx_mem_q <= tx_mem_d;
      rx_mem_q <= rx_mem_d;
      if (Reset_i) begin
         tx_wr_q   <= '0;
         tx_rd_q   <= '0;
         tx_cnt_q  <= '0;
         rx_wr_q   <= '0;
         rx_rd_q   <= '0;
         rx_cnt_q  <= '0;
         tx_full_q <= 1'b0;
         state_q   <= IDLE;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         lsbfe_q   <= 1'b0;
         half_q    <= '0;
         div_q     <= '0;
         edge_q    <= '0;
         tx_word_q <= '0;
         rx_word_q <= '0;
         sck_q     <= CPOL_i;
         mosi_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         tx_wr_q   <= tx_wr_d;
         tx_rd_q   <= tx_rd_d;
         tx_cnt_q  <= tx_cnt_d;
         rx_wr_q   <= rx_wr_d;
         rx_rd_q   <= rx_rd_d;
         rx_cnt_q  <= rx_cnt_d;
         tx_full_q <= tx_full_d;
         state_q   <= state_d;
         cpol_q    <= cpol_d;
         cpha_q    <= cpha_d;
         lsbfe_q   <= lsbfe_d;
         half_q    <= half_d;
         div_q     <= div_d;
         edge_q    <= edge_d;
         tx_word_q <= tx_word_d;
         rx_word_q <= rx_word_d;
         sck_q     <= sck_d;
         mosi_q    <= mosi_d;
         busy_q    <= busy_d;
      end
   end

   assign Data_o         = (rx_cnt_q == '0) ? '0 : rx_mem_q[rx_rd_q];
   assign FIFOEmpty_o    = (rx_cnt_q == '0);
   assign FIFOFull_o     = tx_full_q;
   assign Transmission_o = busy_q;
   assign SCK_o          = sck_q;
   assign MOSI_o         = mosi_q;
endmodule

// File: tb/tb_spi_master_fifo.sv
// Bench for spi_master_fifo: vector table, hand-timed corner sequences, and
// randomized loopback bursts checked against a queue model.
module tb_spi_master_fifo;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, cpol, cpha, lsbfe, wr, rd;
   logic [3:0] sppr;
   logic [2:0] spr;
   logic [7:0] din, dout;
   logic       full, empty, busy, sck, mosi, miso;

   // Simple SPI slave: counts SCK edges within a word and drives the bit due next.
   logic       loop;
   logic [7:0] s_word;
   logic       s_cpha, s_lsbfe, s_sck;
   int         s_n;

   int tests = 0;
   int fails = 0;
   logic [7:0] got[$];
   logic [7:0] model[$];

   typedef struct {
      logic       cpol, cpha, lsbfe;
      logic [3:0] sppr;
      logic [2:0] spr;
      logic [7:0] data;
      logic [7:0] exp_rx;
      int         exp_busy;
   } vec_t;
   vec_t vecs[5];

   spi_master_fifo dut (
      .Clk_i(clk), .Reset_i(rst), .CPOL_i(cpol), .CPHA_i(cpha), .LSBFE_i(lsbfe),
      .SPPR_i(sppr), .SPR_i(spr), .Write_i(wr), .Data_i(din), .ReadNext_i(rd),
      .Data_o(dout), .FIFOFull_o(full), .FIFOEmpty_o(empty), .Transmission_o(busy),
      .SCK_o(sck), .MOSI_o(mosi), .MISO_i(miso)
   );

   always @(negedge clk) begin
      if (rst || !busy) s_n <= 0;
      else if (sck != s_sck) s_n <= (s_n + 1) % 16;
      s_sck <= sck;
   end

   always_comb begin
      automatic int k = s_cpha ? s_n / 2 : (s_n + 1) / 2;
      miso = 1'b0;
      if (loop) miso = mosi;
      else if (k <= 7) miso = s_word[s_lsbfe ? k : 7 - k];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pop_chk(input string name, input logic [7:0] exp);
      chk({name, " nonempty"}, empty, 0);
      chk({name, " data"}, dout, exp);
      rd = 1; tick(); rd = 0;
   endtask

   task automatic wait_idle(input string name, input int bound);
      int c = 0;
      while (busy && c < bound) begin tick(); c++; end
      chk({name, " idle timeout"}, c < bound, 1);
   endtask

   task automatic drain(input string name, input int bound);
      int c = 0;
      got.delete();
      while ((busy || !empty) && c < bound) begin
         if (!empty) begin got.push_back(dout); rd = 1; end
         else rd = 0;
         tick(); c++;
      end
      rd = 0;
      chk({name, " drain timeout"}, c < bound, 1);
   endtask

   task automatic cmp_model(input string name);
      chk({name, " count"}, got.size(), model.size());
      for (int i = 0; i < got.size() && i < model.size(); i++)
         chk($sformatf("%s word%0d", name, i), got[i], model[i]);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int h, nb, k;
      logic [7:0] mw;
      cpol = v.cpol; cpha = v.cpha; lsbfe = v.lsbfe; sppr = v.sppr; spr = v.spr; loop = 1;
      h = (int'(v.sppr) + 1) << v.spr;
      tick();
      wr = 1; din = v.data; tick(); wr = 0; tick();
      nb = 0; mw = 0;
      while (busy && nb < 40000) begin
         if (v.cpha ? (nb % (2*h) == h) : (nb % (2*h) == 0)) begin
            k = nb / (2*h);
            if (k < 8) mw[v.lsbfe ? k : 7 - k] = mosi;
         end
         nb++; tick();
      end
      chk($sformatf("vec%0d busy clocks", idx), nb, v.exp_busy);
      chk($sformatf("vec%0d sck idle", idx), sck, v.cpol);
      chk($sformatf("vec%0d mosi idle", idx), mosi, 0);
      chk($sformatf("vec%0d mosi bits", idx), mw, v.data);
      pop_chk($sformatf("vec%0d rx", idx), v.exp_rx);
      chk($sformatf("vec%0d rx empty", idx), empty, 1);
      chk($sformatf("vec%0d data_o empty", idx), dout, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int nb, tog, first, w, n;
      logic prev;
      vecs[0] = '{1'b1, 1'b1, 1'b0, 4'd0, 3'd0, 8'h5A, 8'h5A, 16};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 4'd1, 3'd1, 8'hA7, 8'hA7, 64};
      vecs[2] = '{1'b0, 1'b1, 1'b1, 4'd2, 3'd0, 8'h3C, 8'h3C, 48};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 4'd0, 3'd2, 8'hC1, 8'hC1, 64};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 4'd3, 3'd1, 8'h81, 8'h81, 128};

      rst = 1; cpol = 0; cpha = 0; lsbfe = 0; sppr = 0; spr = 0; wr = 0; rd = 0; din = 0;
      loop = 1; s_word = 0; s_cpha = 0; s_lsbfe = 0;
      tick(); tick();
      chk("reset full", full, 0);
      chk("reset empty", empty, 1);
      chk("reset busy", busy, 0);
      chk("reset data_o", dout, 0);
      chk("reset mosi", mosi, 0);
      chk("reset sck", sck, 0);
      rst = 0; tick();

      // Abort mid-word
      cpol = 1; sppr = 1; tick();
      wr = 1; din = 8'hFF; tick(); wr = 0;
      for (int i = 0; i < 12; i++) tick();
      chk("abort busy before", busy, 1);
      rst = 1; tick(); rst = 0;
      chk("abort sck", sck, 1);
      chk("abort empty", empty, 1);
      chk("abort full", full, 0);
      chk("abort busy", busy, 0);
      for (int i = 0; i < 40; i++) tick();
      chk("abort no rx word", empty, 1);
      chk("abort stays idle", busy, 0);

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // Back-to-back words against slave returning 0xC3
      loop = 0; s_word = 8'hC3; s_cpha = 0; s_lsbfe = 1;
      cpol = 0; cpha = 0; lsbfe = 1; sppr = 1; spr = 1; tick();
      wr = 1; din = 8'h01; tick(); din = 8'h80; tick(); wr = 0;
      chk("b2b first mosi", mosi, 1);
      nb = 0; tog = 0; prev = sck;
      while (busy && nb < 1000) begin
         nb++; tick();
         if (sck != prev) tog++;
         prev = sck;
      end
      chk("b2b busy clocks", nb, 128);
      chk("b2b sck edges", tog, 32);
      pop_chk("b2b rx0", 8'hC3);
      pop_chk("b2b rx1", 8'hC3);
      chk("b2b rx empty", empty, 1);

      // TX full: 1 goes to the engine, 2..5 fill the FIFO, 6 is dropped
      loop = 1; cpol = 0; cpha = 0; lsbfe = 0; sppr = 15; spr = 7; tick();
      for (int v = 1; v <= 6; v++) begin wr = 1; din = 8'(v); tick(); end
      wr = 0;
      chk("txfull flag", full, 1);
      sppr = 0; spr = 0;
      for (int i = 0; i < 5; i++) tick();
      chk("txfull flag held", full, 1);
      drain("txfull", 40000);
      model.delete();
      for (int v = 1; v <= 5; v++) model.push_back(8'(v));
      cmp_model("txfull");

      // RX overflow drops the newest word
      cpha = 1; tick();
      for (int v = 1; v <= 5; v++) begin wr = 1; din = 8'(v); tick(); end
      wr = 0;
      wait_idle("rxovf", 500);
      for (int v = 1; v <= 4; v++) pop_chk($sformatf("rxovf pop%0d", v), 8'(v));
      chk("rxovf lost fifth", empty, 1);

      // Same burst, popping on the fifth completion cycle keeps every word
      for (int v = 11; v <= 15; v++) begin wr = 1; din = 8'(v); tick(); end
      wr = 0;
      w = 0;
      while (empty && w < 200) begin tick(); w++; end
      chk("rxsim first done", w < 200, 1);
      for (int i = 0; i < 63; i++) tick();
      rd = 1; tick(); rd = 0;
      wait_idle("rxsim", 500);
      for (int v = 12; v <= 15; v++) pop_chk($sformatf("rxsim pop%0d", v), 8'(v));
      chk("rxsim empty", empty, 1);

      // Config change mid-word only affects the following word
      cpol = 0; cpha = 0; lsbfe = 1; sppr = 0; spr = 0; tick();
      wr = 1; din = 8'hA5; tick(); din = 8'h3C; tick(); wr = 0;
      nb = 0; first = -1;
      while (busy && nb < 1000) begin
         if (nb == 3) begin cpha = 1; spr = 1; end
         nb++; tick();
         if (first < 0 && !empty) first = nb;
      end
      chk("cfg first word clocks", first, 16);
      chk("cfg total clocks", nb, 48);
      pop_chk("cfg rx0", 8'hA5);
      pop_chk("cfg rx1", 8'h3C);

      // Randomized loopback bursts
      for (int r = 0; r < 4; r++) begin
         cpol = 1'($urandom_range(0, 1)); cpha = 1'($urandom_range(0, 1));
         lsbfe = 1'($urandom_range(0, 1));
         sppr = 4'($urandom_range(0, 2)); spr = 3'($urandom_range(0, 1));
         loop = 1; tick();
         n = $urandom_range(2, 6);
         model.delete();
         for (int j = 0; j < n; j++) begin
            w = 0;
            while (full && w < 5000) begin tick(); w++; end
            chk($sformatf("rand%0d full wait", r), w < 5000, 1);
            wr = 1; din = 8'($urandom); model.push_back(din); tick(); wr = 0;
         end
         tick();
         drain($sformatf("rand%0d", r), 20000);
         cmp_model($sformatf("rand%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
